// File: rtl/sonar_scan_sequencer.sv
// Steps one shared ultrasound ranging unit across five sensor slots and reports the nearest echo.
// Optional: define SONAR_BIDIR_SWEEP_EN to alternate the sweep direction on every completed scan.
module sonar_scan_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1620000,
   parameter int unsigned SETTLE_CYCLES  = 270000,
   parameter logic [7:0]  NO_ECHO_DIST   = 8'hFF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        scan_start,
   input  logic        scan_abort,
   input  logic        continuous,
   output logic        range_start,
   output logic [2:0]  range_sel,
   input  logic        range_done,
   input  logic [7:0]  range_value,
   output logic [39:0] slot_dists,
   output logic [4:0]  timeout_flags,
   output logic [2:0]  min_index,
   output logic [7:0]  min_dist,
   output logic        result_valid,
   output logic        busy
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FIRE,
      ST_WAIT,
      ST_SETTLE,
      ST_COMPARE,
      ST_REPORT
   } state_t;

   state_t           state, state_next;
   logic [2:0]       slot, slot_next;
   logic [CNT_W-1:0] timer, timer_next;
   logic             store_en;
   logic [7:0]       store_val;
   logic             set_flag;
   logic             clear_flags;
   logic             load_min;
   logic [2:0]       first_slot, last_slot, next_slot;
   logic [2:0]       best_index;
   logic [7:0]       best_dist;

`ifdef SONAR_BIDIR_SWEEP_EN
   logic sweep_down;

   // Direction flips only when a scan actually reaches REPORT, so aborted scans keep it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sweep_down <= 1'b0;
      end else if (state == ST_COMPARE && state_next == ST_REPORT) begin
         sweep_down <= ~sweep_down;
      end
   end

   assign first_slot = sweep_down ? 3'd5 : 3'd1;
   assign last_slot  = sweep_down ? 3'd1 : 3'd5;
   assign next_slot  = sweep_down ? slot - 3'd1 : slot + 3'd1;
`else
   assign first_slot = 3'd1;
   assign last_slot  = 3'd5;
   assign next_slot  = slot + 3'd1;
`endif

   always_comb begin
      state_next  = state;
      slot_next   = slot;
      timer_next  = timer;
      store_en    = 1'b0;
      store_val   = range_value;
      set_flag    = 1'b0;
      clear_flags = 1'b0;
      load_min    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (scan_start || continuous) begin
               state_next  = ST_FIRE;
               slot_next   = first_slot;
               clear_flags = 1'b1;
            end
         end
         ST_FIRE: begin
            state_next = ST_WAIT;
            timer_next = '0;
         end
         ST_WAIT: begin
            // An echo arriving on the timeout cycle still counts as a real measurement.
            if (range_done) begin
               store_en   = 1'b1;
               state_next = ST_SETTLE;
               timer_next = '0;
            end else if (timer == TIMEOUT_LAST) begin
               store_en   = 1'b1;
               store_val  = NO_ECHO_DIST;
               set_flag   = 1'b1;
               state_next = ST_SETTLE;
               timer_next = '0;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         ST_SETTLE: begin
            if (timer == SETTLE_LAST) begin
               timer_next = '0;
               if (slot == last_slot) begin
                  state_next = ST_COMPARE;
               end else begin
                  slot_next  = next_slot;
                  state_next = ST_FIRE;
               end
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         ST_COMPARE: begin
            load_min   = 1'b1;
            state_next = ST_REPORT;
         end
         ST_REPORT: begin
            if (continuous) begin
               state_next  = ST_FIRE;
               slot_next   = first_slot;
               clear_flags = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (scan_abort) begin
         state_next  = ST_IDLE;
         slot_next   = slot;
         timer_next  = '0;
         store_en    = 1'b0;
         set_flag    = 1'b0;
         clear_flags = 1'b0;
         load_min    = 1'b0;
      end
   end

   // Strict less-than keeps the lowest slot on ties and yields slot 1 when all timed out.
   always_comb begin
      best_dist  = slot_dists[7:0];
      best_index = 3'd1;
      for (int k = 1; k < 5; k++) begin
         if (slot_dists[k*8 +: 8] < best_dist) begin
            best_dist  = slot_dists[k*8 +: 8];
            best_index = 3'(k + 1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         slot          <= 3'd0;
         timer         <= '0;
         slot_dists    <= '0;
         timeout_flags <= '0;
         min_index     <= 3'd0;
         min_dist      <= 8'd0;
      end else begin
         state <= state_next;
         slot  <= slot_next;
         timer <= timer_next;
         if (clear_flags) begin
            timeout_flags <= '0;
         end
         for (int k = 0; k < 5; k++) begin
            if (store_en && slot == 3'(k + 1)) begin
               slot_dists[k*8 +: 8] <= store_val;
               if (set_flag) begin
                  timeout_flags[k] <= 1'b1;
               end
            end
         end
         if (load_min) begin
            min_index <= best_index;
            min_dist  <= best_dist;
         end
      end
   end

   assign range_start  = (state == ST_FIRE);
   assign range_sel    = (state == ST_IDLE) ? 3'd0 : slot;
   assign result_valid = (state == ST_REPORT);
   assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// Directed testbench for sonar_scan_sequencer with a behavioural ranging-unit responder.
// Expectations for the sweep order follow SONAR_BIDIR_SWEEP_EN when it is defined.
module tb_sonar_scan_sequencer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        scan_start = 1'b0;
   logic        scan_abort = 1'b0;
   logic        continuous = 1'b0;
   logic        range_done = 1'b0;
   logic [7:0]  range_value = 8'd0;
   logic        range_start;
   logic [2:0]  range_sel;
   logic [39:0] slot_dists;
   logic [4:0]  timeout_flags;
   logic [2:0]  min_index;
   logic [7:0]  min_dist;
   logic        result_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int         resp_delay [5];
   logic [7:0] resp_value [5];
   logic [4:0] resp_mask = 5'b11111;
   logic       pend = 1'b0;
   int         pend_cnt = 0;
   logic [7:0] pend_val = 8'd0;
   logic [2:0] sel_log [128];
   int         sel_count = 0;
   int         rv_count = 0;
   int         s;

   sonar_scan_sequencer #(
      .TIMEOUT_CYCLES(20),
      .SETTLE_CYCLES(4),
      .NO_ECHO_DIST(8'hFF)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .scan_start(scan_start),
      .scan_abort(scan_abort),
      .continuous(continuous),
      .range_start(range_start),
      .range_sel(range_sel),
      .range_done(range_done),
      .range_value(range_value),
      .slot_dists(slot_dists),
      .timeout_flags(timeout_flags),
      .min_index(min_index),
      .min_dist(min_dist),
      .result_valid(result_valid),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Ranging unit model: answers a ping on slot k after resp_delay[k-1] cycles if unmasked.
   initial begin
      forever begin
         @(negedge clock);
         range_done = 1'b0;
         if (pend) begin
            if (pend_cnt <= 1) begin
               range_done  = 1'b1;
               range_value = pend_val;
               pend        = 1'b0;
            end else begin
               pend_cnt = pend_cnt - 1;
            end
         end
         if (range_start === 1'b1) begin
            s = int'(range_sel);
            if (sel_count < 128) sel_log[sel_count] = range_sel;
            sel_count++;
            if (s >= 1 && s <= 5 && resp_mask[s-1]) begin
               pend     = 1'b1;
               pend_cnt = resp_delay[s-1];
               pend_val = resp_value[s-1];
            end
         end
         if (result_valid === 1'b1) rv_count++;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      scan_start = 1'b0;
      scan_abort = 1'b0;
      continuous = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic set_resp(input logic [39:0] vals, input int dly, input logic [4:0] mask);
      for (int k = 0; k < 5; k++) begin
         resp_value[k] = vals[k*8 +: 8];
         resp_delay[k] = dly;
      end
      resp_mask = mask;
   endtask

   task automatic start_scan();
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
   endtask

   task automatic wait_report(output int cyc);
      cyc = 1;
      while (result_valid !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({range_start, range_sel, busy, result_valid, timeout_flags, min_index, min_dist, slot_dists} !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {range_start, range_sel, busy, result_valid, timeout_flags, min_index, min_dist, slot_dists});
      end
      reset_n = 1'b1;
      tick(2);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_single_scan();
      int cyc, base_sel, base_rv;
      do_reset();
      set_resp(40'h320A141E28, 3, 5'b11111);
      base_sel = sel_count;
      base_rv  = rv_count;
      start_scan();
      checks++;
      if (range_start !== 1'b1 || range_sel !== 3'd1) begin
         errors++;
         $display("[TB] FAIL single_fire: got start=%b sel=%0d expected start=1 sel=1", range_start, range_sel);
      end
      wait_report(cyc);
      checks++;
      if (cyc != 42) begin
         errors++;
         $display("[TB] FAIL single_report_cycle: got %0d expected 42", cyc);
      end
      tick(3);
      checks++;
      if (rv_count - base_rv != 1) begin
         errors++;
         $display("[TB] FAIL single_rv_pulses: got %0d expected 1", rv_count - base_rv);
      end
      checks++;
      if (sel_count - base_sel != 5) begin
         errors++;
         $display("[TB] FAIL single_fire_count: got %0d expected 5", sel_count - base_sel);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (sel_log[base_sel + i] !== 3'(i + 1)) begin
            errors++;
            $display("[TB] FAIL single_sel_order[%0d]: got %0d expected %0d", i, sel_log[base_sel + i], i + 1);
         end
      end
      checks++;
      if (min_index !== 3'd4 || min_dist !== 8'd10) begin
         errors++;
         $display("[TB] FAIL single_min: got idx=%0d dist=%0d expected idx=4 dist=10", min_index, min_dist);
      end
      checks++;
      if (timeout_flags !== 5'b0) begin
         errors++;
         $display("[TB] FAIL single_flags: got %b expected 00000", timeout_flags);
      end
      checks++;
      if (slot_dists !== 40'h320A141E28) begin
         errors++;
         $display("[TB] FAIL single_dists: got %h expected 320a141e28", slot_dists);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_idle_after: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_latency();
      int cyc;
      do_reset();
      set_resp(40'hFA326496C8, 1, 5'b11111);
      start_scan();
      wait_report(cyc);
      checks++;
      if (cyc != 32) begin
         errors++;
         $display("[TB] FAIL latency_cycle: got %0d expected 32", cyc);
      end
      checks++;
      if (min_index !== 3'd4 || min_dist !== 8'h32) begin
         errors++;
         $display("[TB] FAIL latency_min: got idx=%0d dist=%h expected idx=4 dist=32", min_index, min_dist);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      do_reset();
      set_resp(40'h50463C005A, 3, 5'b11101);
      start_scan();
      wait_report(cyc);
      checks++;
      if (cyc != 59) begin
         errors++;
         $display("[TB] FAIL timeout_report_cycle: got %0d expected 59", cyc);
      end
      checks++;
      if (timeout_flags !== 5'b00010) begin
         errors++;
         $display("[TB] FAIL timeout_flags: got %b expected 00010", timeout_flags);
      end
      checks++;
      if (slot_dists !== 40'h50463CFF5A) begin
         errors++;
         $display("[TB] FAIL timeout_dists: got %h expected 50463cff5a", slot_dists);
      end
      checks++;
      if (min_index !== 3'd3 || min_dist !== 8'd60) begin
         errors++;
         $display("[TB] FAIL timeout_min: got idx=%0d dist=%0d expected idx=3 dist=60", min_index, min_dist);
      end
   endtask

   task automatic test_tie_and_late_echo();
      int cyc;
      do_reset();
      set_resp(40'h5A195A1919, 3, 5'b11111);
      start_scan();
      wait_report(cyc);
      checks++;
      if (min_index !== 3'd1 || min_dist !== 8'd25) begin
         errors++;
         $display("[TB] FAIL tie_min: got idx=%0d dist=%0d expected idx=1 dist=25", min_index, min_dist);
      end
      tick(2);
      set_resp(40'h6464076464, 3, 5'b11111);
      resp_delay[2] = 20;
      start_scan();
      wait_report(cyc);
      checks++;
      if (cyc != 59) begin
         errors++;
         $display("[TB] FAIL late_echo_cycle: got %0d expected 59", cyc);
      end
      checks++;
      if (timeout_flags !== 5'b0) begin
         errors++;
         $display("[TB] FAIL late_echo_flags: got %b expected 00000", timeout_flags);
      end
      checks++;
      if (slot_dists !== 40'h6464076464) begin
         errors++;
         $display("[TB] FAIL late_echo_dists: got %h expected 6464076464", slot_dists);
      end
      checks++;
      if (min_index !== 3'd3 || min_dist !== 8'd7) begin
         errors++;
         $display("[TB] FAIL late_echo_min: got idx=%0d dist=%0d expected idx=3 dist=7", min_index, min_dist);
      end
   endtask

   task automatic test_continuous();
      int base_sel, base_rv, busy_low, rv1, rv2;
      logic [2:0] exp_order [10];
`ifdef SONAR_BIDIR_SWEEP_EN
      exp_order = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
`else
      exp_order = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
`endif
      do_reset();
      set_resp(40'h320A141E28, 3, 5'b11111);
      base_sel = sel_count;
      base_rv  = rv_count;
      busy_low = 0;
      rv1 = 0;
      rv2 = 0;
      continuous = 1'b1;
      tick();
      for (int c = 1; c <= 84; c++) begin
         if (busy !== 1'b1) busy_low++;
         if (result_valid === 1'b1) begin
            if (rv1 == 0) rv1 = c;
            else rv2 = c;
         end
         if (c == 43) begin
            checks++;
            if (range_start !== 1'b1 || range_sel !== exp_order[5]) begin
               errors++;
               $display("[TB] FAIL cont_restart: got start=%b sel=%0d expected start=1 sel=%0d",
                        range_start, range_sel, exp_order[5]);
            end
         end
         if (c == 50) continuous = 1'b0;
         tick();
      end
      checks++;
      if (busy_low != 0) begin
         errors++;
         $display("[TB] FAIL cont_busy_gap: got %0d low cycles expected 0", busy_low);
      end
      checks++;
      if (rv1 != 42 || rv2 != 84) begin
         errors++;
         $display("[TB] FAIL cont_rv_cycles: got %0d,%0d expected 42,84", rv1, rv2);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cont_stop: got busy=%b expected 0", busy);
      end
      tick(2);
      checks++;
      if (rv_count - base_rv != 2 || sel_count - base_sel != 10) begin
         errors++;
         $display("[TB] FAIL cont_counts: got rv=%0d fires=%0d expected rv=2 fires=10",
                  rv_count - base_rv, sel_count - base_sel);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (sel_log[base_sel + i] !== exp_order[i]) begin
            errors++;
            $display("[TB] FAIL cont_sel_order[%0d]: got %0d expected %0d", i, sel_log[base_sel + i], exp_order[i]);
         end
      end
   endtask

   task automatic test_abort();
      int cyc, base_rv;
      logic [39:0] exp_dists;
`ifdef SONAR_BIDIR_SWEEP_EN
      exp_dists = 40'h0F0E141E28;
`else
      exp_dists = 40'h320A140C0B;
`endif
      do_reset();
      set_resp(40'h320A141E28, 3, 5'b11111);
      start_scan();
      wait_report(cyc);
      tick(2);
      set_resp(40'h0F0E0D0C0B, 3, 5'b11111);
      resp_delay[2] = 10;
      base_rv = rv_count;
      start_scan();
      tick(19);
      checks++;
      if (busy !== 1'b1 || range_sel !== 3'd3) begin
         errors++;
         $display("[TB] FAIL abort_pre_wait: got busy=%b sel=%0d expected busy=1 sel=3", busy, range_sel);
      end
      scan_abort = 1'b1;
      tick();
      scan_abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || range_sel !== 3'd0) begin
         errors++;
         $display("[TB] FAIL abort_idle: got busy=%b sel=%0d expected busy=0 sel=0", busy, range_sel);
      end
      tick(14);
      checks++;
      if (busy !== 1'b0 || range_start !== 1'b0 || rv_count - base_rv != 0) begin
         errors++;
         $display("[TB] FAIL abort_stray_done: got busy=%b start=%b rv=%0d expected 0,0,0",
                  busy, range_start, rv_count - base_rv);
      end
      checks++;
      if (min_index !== 3'd4 || min_dist !== 8'd10) begin
         errors++;
         $display("[TB] FAIL abort_min_kept: got idx=%0d dist=%0d expected idx=4 dist=10", min_index, min_dist);
      end
      checks++;
      if (slot_dists !== exp_dists) begin
         errors++;
         $display("[TB] FAIL abort_dists: got %h expected %h", slot_dists, exp_dists);
      end
   endtask

   task automatic test_back_to_back_reset();
      int cyc;
      logic [2:0] first_sel, second_sel;
`ifdef SONAR_BIDIR_SWEEP_EN
      first_sel  = 3'd5;
      second_sel = 3'd4;
`else
      first_sel  = 3'd1;
      second_sel = 3'd2;
`endif
      do_reset();
      set_resp(40'h320A141E28, 3, 5'b11111);
      start_scan();
      wait_report(cyc);
      tick(2);
      set_resp(40'h0F0E0D0C0B, 3, 5'b11111);
      start_scan();
      tick(4);
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick();
      checks++;
      if (range_start !== 1'b0 || range_sel !== first_sel) begin
         errors++;
         $display("[TB] FAIL busy_start_ignored: got start=%b sel=%0d expected start=0 sel=%0d",
                  range_start, range_sel, first_sel);
      end
      tick(2);
      checks++;
      if (range_start !== 1'b1 || range_sel !== second_sel) begin
         errors++;
         $display("[TB] FAIL busy_order_intact: got start=%b sel=%0d expected start=1 sel=%0d",
                  range_start, range_sel, second_sel);
      end
      tick(5);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({range_start, range_sel, busy, result_valid, timeout_flags, min_index, min_dist, slot_dists} !== 64'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h expected 0",
                  {range_start, range_sel, busy, result_valid, timeout_flags, min_index, min_dist, slot_dists});
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_scan();
      test_latency();
      test_timeout();
      test_tie_and_late_echo();
      test_continuous();
      test_abort();
      test_back_to_back_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
